dm_responder: RTL and testbench
===============================

// Module: dm_responder
// PURPOSE
//   Data-memory responder at the far end of the CPU data-memory port. Accepts the core's
//   MEM-stage address, store data, mem_w and DMType and returns load data in the same cycle.
//   Performs byte/half/word stores with lane merging and sign/zero-extended loads.
//   A post-reset clear FSM zeroes the array, misaligned accesses are trapped and accepted
//   stores are counted.
// PARAMETERS
//   DEPTH_LOG2   7    log2 of word count (default 128 x 32-bit words)
//   CNT_W        16   width of wr_count
// PORTS
//   clk        in   1           rising-edge clock
//   reset      in   1           synchronous, active-low reset
//   mem_w      in   1           store request this cycle
//   addr_in    in   32          byte address; word index = addr_in[DEPTH_LOG2+1:2], upper bits ignored (alias)
//   din        in   32          store data, right-aligned (byte in [7:0], half in [15:0])
//   DMType     in   3           000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned
//   dout       out  32          load data, combinational, extended per DMType
//   init_busy  out  1           clear FSM active; stores ignored, dout forced to 0
//   misalign   out  1           sticky misaligned-access flag
//   err_addr   out  32          address of first misaligned access since last clear
//   err_clr    in   1           clears misalign and err_addr
//   wr_count   out  CNT_W       number of accepted stores, saturating
// BEHAVIOUR
//   Reset (reset==0 at a clk edge): state<=INIT, clear index<=0, misalign<=0, err_addr<=0, wr_count<=0.
//   Reset values: init_busy=1, dout=0, misalign=0, err_addr=0, wr_count=0.
//   FSM INIT: each cycle write 0 to word[idx], idx++. At idx==2^DEPTH_LOG2-1: write it, go to READY.
//     INIT takes exactly 2^DEPTH_LOG2 cycles after reset is released.
//     Reset asserted mid-INIT restarts INIT at idx 0. READY is held until the next reset.
//   In INIT: mem_w ignored, no counting, no misalign detection, dout=0.
//   READY store (mem_w=1, aligned): write takes effect on the clk edge.
//     word: whole word.
//     half: lanes addr[1]?[31:16]:[15:0] <= din[15:0]; other lanes unchanged.
//     byte: lane addr[1:0] <= din[7:0]; other lanes unchanged.
//     wr_count increments and saturates at all-ones.
//   READY load (every cycle): byte/half selected by addr[1:0], then sign- or zero-extended.
//     dout updates combinationally from the current array contents.
//   Read-during-write to the same word: dout shows the pre-write contents that cycle and the
//     new contents from the next cycle.
//   Misaligned: word with addr[1:0]!=0, or half with addr[0]!=0 (byte accesses are never misaligned).
//     Misaligned store: suppressed, not counted.
//     Misaligned load (mem_w=0): dout=0.
//     Either: if misalign==0, then misalign<=1 and err_addr<=addr_in; later events keep the first address.
//   err_clr with a simultaneous new misaligned access: the new event wins, so misalign stays 1
//     and err_addr<=addr_in.
//   Undefined DMType (101-111): treated as word.
// TESTING
//   1. Release reset and hold 128 cycles:
//      -> init_busy=1 for exactly 128 cycles, then 0.
//      -> read of any address returns 0.
//   2. sw 0x11223344 @0x10, then sb 0xAB @0x12:
//      -> lw @0x10 = 0x11AB3344, lb @0x12 = 0xFFFFFFAB, lbu @0x12 = 0x000000AB; wr_count=2.
//   3. sh 0x8001 @0x22:
//      -> lh @0x22 = 0xFFFF8001, lhu @0x22 = 0x00008001, lw @0x20 = 0x80010000.
//   4. sw 0xDEADBEEF @0x31:
//      -> word @0x30 unchanged, misalign=1, err_addr=0x31, wr_count unchanged.
//      -> second misaligned access @0x45 leaves err_addr=0x31.
//      -> err_clr clears misalign and err_addr.
//   5. sw 0x5 @0x40 with dout observed on the same cycle:
//      -> dout shows old value that cycle and 0x5 the next cycle.
//   6. Reset pulsed at INIT cycle 60:
//      -> init_busy stays high for 128 cycles after release.
//      -> a store attempted during INIT is ignored and wr_count=0.

Source files
------------

// File: rtl/dm_responder.sv
// Data-memory responder: single-cycle loads and stores against a word array,
// zeroed by a clear FSM after every reset. Misaligned accesses are trapped in
// a sticky flag with the first offending address. Accepted stores are counted.
//
// Request semantics: there is no handshake. Every cycle in READY the inputs
// form one access. It is a store when mem_w=1, otherwise a load. Loads are
// always answered combinationally on dout. A store commits at the next
// rising clk edge unless it is misaligned. While init_busy=1 all requests
// are ignored.
module dm_responder #(
  parameter int DEPTH_LOG2 = 7,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_w,
  input  logic [31:0]      addr_in,
  input  logic [31:0]      din,
  input  logic [2:0]       DMType,
  output logic [31:0]      dout,
  output logic             init_busy,
  output logic             misalign,
  output logic [31:0]      err_addr,
  input  logic             err_clr,
  output logic [CNT_W-1:0] wr_count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] IDX_ONE = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE = 1;

  // init_busy is the decode of this state and doubles as its debug view.
  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [DEPTH_LOG2-1:0] idx, idx_next;
  logic                  clr_we;

  logic [31:0] mem [DEPTH];

  logic                  ready;
  logic                  is_half, is_byte, is_word, is_signed;
  logic                  misaligned_acc;
  logic                  mis_event;
  logic                  store_ok;
  logic [DEPTH_LOG2-1:0] widx;
  logic [31:0]           rd_word;
  logic [3:0]            byte_en;
  logic [31:0]           lane_data;
  logic [31:0]           merged;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;

  // Clear FSM state register; reset restarts the sweep from word 0.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_INIT;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  // Clear FSM next state: one word zeroed per cycle, READY after the last one.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    clr_we     = 1'b0;
    case (state)
      ST_INIT: begin
        clr_we   = 1'b1;
        idx_next = idx + IDX_ONE;
        if (idx == '1) begin
          state_next = ST_READY;
        end
      end
      ST_READY: begin
        state_next = ST_READY;
      end
      default: begin
        state_next = ST_INIT;
      end
    endcase
  end

  assign init_busy = (state == ST_INIT);
  assign ready     = (state == ST_READY);

  // Access decode. Undefined DMType codes fall through to word.
  always_comb begin
    is_half   = (DMType == 3'b001) || (DMType == 3'b010);
    is_byte   = (DMType == 3'b011) || (DMType == 3'b100);
    is_word   = !is_half && !is_byte;
    is_signed = (DMType == 3'b001) || (DMType == 3'b011);
    misaligned_acc = (is_word && (addr_in[1:0] != 2'b00)) ||
                     (is_half && addr_in[0]);
  end

  assign mis_event = ready && misaligned_acc;
  assign store_ok  = ready && mem_w && !misaligned_acc;
  // Upper address bits are deliberately ignored, so the array aliases.
  assign widx      = addr_in[DEPTH_LOG2+1:2];
  assign rd_word   = mem[widx];

  // Lane merge: replicate the right-aligned store data and enable only the
  // lanes the access targets, keeping the old contents elsewhere.
  always_comb begin
    byte_en   = 4'b1111;
    lane_data = din;
    if (is_half) begin
      byte_en   = addr_in[1] ? 4'b1100 : 4'b0011;
      lane_data = {2{din[15:0]}};
    end else if (is_byte) begin
      byte_en   = 4'b0001 << addr_in[1:0];
      lane_data = {4{din[7:0]}};
    end
    for (int i = 0; i < 4; i++) begin
      merged[i*8 +: 8] = byte_en[i] ? lane_data[i*8 +: 8] : rd_word[i*8 +: 8];
    end
  end

  // Array write port: clear sweep during INIT, merged store during READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (clr_we) begin
        mem[idx] <= '0;
      end else if (store_ok) begin
        mem[widx] <= merged;
      end
    end
  end

  // Load path: select the lane, extend, and force zero while clearing or
  // when the access is misaligned. Reads see pre-write contents.
  always_comb begin
    half_sel = addr_in[1] ? rd_word[31:16] : rd_word[15:0];
    byte_sel = rd_word[{addr_in[1:0], 3'b000} +: 8];
    dout     = '0;
    if (ready && !misaligned_acc) begin
      if (is_half) begin
        dout = is_signed ? {{16{half_sel[15]}}, half_sel} : {16'h0000, half_sel};
      end else if (is_byte) begin
        dout = is_signed ? {{24{byte_sel[7]}}, byte_sel} : {24'h000000, byte_sel};
      end else begin
        dout = rd_word;
      end
    end
  end

  // Sticky misalign capture and saturating store counter. A new misaligned
  // event beats a simultaneous err_clr so it is never lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      misalign <= 1'b0;
      err_addr <= '0;
      wr_count <= '0;
    end else begin
      if (mis_event && (!misalign || err_clr)) begin
        misalign <= 1'b1;
        err_addr <= addr_in;
      end else if (err_clr) begin
        misalign <= 1'b0;
        err_addr <= '0;
      end
      if (store_ok && (wr_count != '1)) begin
        wr_count <= wr_count + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: vector table for single-cycle accesses,
// hand-written sequences for clear timing, reset restart and saturation.
module tb_dm_responder;

  localparam int W_ = 3'd0;

  logic        clk;
  logic        reset;
  logic        mem_w;
  logic [31:0] addr_in;
  logic [31:0] din;
  logic [2:0]  dm_type;
  logic [31:0] dout;
  logic        init_busy;
  logic        misalign;
  logic [31:0] err_addr;
  logic        err_clr;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;

  dm_responder #(.DEPTH_LOG2(7), .CNT_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_w     (mem_w),
    .addr_in   (addr_in),
    .din       (din),
    .DMType    (dm_type),
    .dout      (dout),
    .init_busy (init_busy),
    .misalign  (misalign),
    .err_addr  (err_addr),
    .err_clr   (err_clr),
    .wr_count  (wr_count)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [2:0] T_W  = 3'b000;
  localparam logic [2:0] T_HS = 3'b001;
  localparam logic [2:0] T_HU = 3'b010;
  localparam logic [2:0] T_BS = 3'b011;
  localparam logic [2:0] T_BU = 3'b100;

  typedef struct {
    logic        w;
    logic        clr;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_dout;
    logic        exp_mis;
    logic [31:0] exp_err;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic w, input logic clr, input logic [2:0] typ,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [31:0] exp_dout, input logic exp_mis,
                              input logic [31:0] exp_err, input logic [15:0] exp_cnt);
    vec_t v;
    v.w = w; v.clr = clr; v.typ = typ; v.addr = addr; v.data = data;
    v.exp_dout = exp_dout; v.exp_mis = exp_mis; v.exp_err = exp_err; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic w, input logic clr, input logic [2:0] typ,
                       input logic [31:0] addr, input logic [31:0] data);
    mem_w   = w;
    err_clr = clr;
    dm_type = typ;
    addr_in = addr;
    din     = data;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, T_W, 32'h0, 32'h0);
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  initial begin
    int n;
    int sat_n;

    // Vector table: {store, clr, type, addr, din} -> {dout this cycle,
    // misalign / err_addr / wr_count after the edge}
    vecs.push_back(mk(0,0,T_W ,32'h000,32'h0       ,32'h00000000,0,32'h00,16'd0));
    vecs.push_back(mk(0,0,T_W ,32'h1FC,32'h0       ,32'h00000000,0,32'h00,16'd0));
    vecs.push_back(mk(1,0,T_W ,32'h010,32'h11223344,32'h00000000,0,32'h00,16'd1));
    vecs.push_back(mk(1,0,T_BS,32'h012,32'h000000AB,32'h00000022,0,32'h00,16'd2));
    vecs.push_back(mk(0,0,T_W ,32'h010,32'h0       ,32'h11AB3344,0,32'h00,16'd2));
    vecs.push_back(mk(0,0,T_BS,32'h012,32'h0       ,32'hFFFFFFAB,0,32'h00,16'd2));
    vecs.push_back(mk(0,0,T_BU,32'h012,32'h0       ,32'h000000AB,0,32'h00,16'd2));
    vecs.push_back(mk(1,0,T_HS,32'h022,32'h00008001,32'h00000000,0,32'h00,16'd3));
    vecs.push_back(mk(0,0,T_HS,32'h022,32'h0       ,32'hFFFF8001,0,32'h00,16'd3));
    vecs.push_back(mk(0,0,T_HU,32'h022,32'h0       ,32'h00008001,0,32'h00,16'd3));
    vecs.push_back(mk(0,0,T_W ,32'h020,32'h0       ,32'h80010000,0,32'h00,16'd3));
    vecs.push_back(mk(0,0,T_HS,32'h020,32'h0       ,32'h00000000,0,32'h00,16'd3));
    vecs.push_back(mk(1,0,T_BU,32'h013,32'h0000007F,32'h00000011,0,32'h00,16'd4));
    vecs.push_back(mk(0,0,T_W ,32'h010,32'h0       ,32'h7FAB3344,0,32'h00,16'd4));
    vecs.push_back(mk(0,0,T_HU,32'h012,32'h0       ,32'h00007FAB,0,32'h00,16'd4));
    vecs.push_back(mk(0,0,T_HS,32'h010,32'h0       ,32'h00003344,0,32'h00,16'd4));
    vecs.push_back(mk(0,0,3'b111,32'h010,32'h0     ,32'h7FAB3344,0,32'h00,16'd4));
    vecs.push_back(mk(1,0,T_HU,32'h010,32'hFFFF1234,32'h00003344,0,32'h00,16'd5));
    vecs.push_back(mk(0,0,T_W ,32'h010,32'h0       ,32'h7FAB1234,0,32'h00,16'd5));
    vecs.push_back(mk(0,0,T_BS,32'h011,32'h0       ,32'h00000012,0,32'h00,16'd5));
    vecs.push_back(mk(0,0,T_W ,32'h030,32'h0       ,32'h00000000,0,32'h00,16'd5));
    vecs.push_back(mk(1,0,T_W ,32'h031,32'hDEADBEEF,32'h00000000,1,32'h31,16'd5));
    vecs.push_back(mk(0,0,T_W ,32'h030,32'h0       ,32'h00000000,1,32'h31,16'd5));
    vecs.push_back(mk(0,0,T_HS,32'h045,32'h0       ,32'h00000000,1,32'h31,16'd5));
    vecs.push_back(mk(0,0,T_BS,32'h045,32'h0       ,32'h00000000,1,32'h31,16'd5));
    vecs.push_back(mk(0,1,T_W ,32'h030,32'h0       ,32'h00000000,0,32'h00,16'd5));
    vecs.push_back(mk(0,1,T_HU,32'h047,32'h0       ,32'h00000000,1,32'h47,16'd5));
    vecs.push_back(mk(0,1,T_W ,32'h000,32'h0       ,32'h00000000,0,32'h00,16'd5));
    vecs.push_back(mk(1,0,T_W ,32'h040,32'h00000005,32'h00000000,0,32'h00,16'd6));
    vecs.push_back(mk(0,0,T_W ,32'h040,32'h0       ,32'h00000005,0,32'h00,16'd6));
    vecs.push_back(mk(1,0,T_W ,32'h040,32'h00000077,32'h00000005,0,32'h00,16'd7));
    vecs.push_back(mk(0,0,T_W ,32'h040,32'h0       ,32'h00000077,0,32'h00,16'd7));
    vecs.push_back(mk(1,0,T_HS,32'h023,32'h0000BEEF,32'h00000000,1,32'h23,16'd7));
    vecs.push_back(mk(0,0,T_W ,32'h020,32'h0       ,32'h80010000,1,32'h23,16'd7));
    vecs.push_back(mk(0,1,T_W ,32'h000,32'h0       ,32'h00000000,0,32'h00,16'd7));
    vecs.push_back(mk(1,0,3'b101,32'h050,32'hCAFEF00D,32'h00000000,0,32'h00,16'd8));
    vecs.push_back(mk(0,0,T_W ,32'h050,32'h0       ,32'hCAFEF00D,0,32'h00,16'd8));
    vecs.push_back(mk(0,0,3'b110,32'h052,32'h0     ,32'h00000000,1,32'h52,16'd8));
    vecs.push_back(mk(0,1,T_W ,32'h210,32'h0       ,32'h7FAB1234,0,32'h00,16'd8));
    vecs.push_back(mk(0,0,T_BU,32'h213,32'h0       ,32'h0000007F,0,32'h00,16'd8));

    // Reset state
    reset = 1'b0;
    idle();
    repeat (3) tick();
    check("rst_init_busy", {31'b0, init_busy}, 32'h1);
    check("rst_misalign", {31'b0, misalign}, 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    check("rst_wr_count", {16'b0, wr_count}, 32'h0);
    check("rst_dout", dout, 32'h0);

    // Clear sweep lasts exactly 128 cycles after release
    reset = 1'b1;
    n = 0;
    while (init_busy && n < 300) begin
      drive(1'b0, 1'b0, T_W, 32'h10, 32'h0);
      if (n == 5) check("init_dout_zero", dout, 32'h0);
      tick();
      n++;
    end
    check("init_cycles", n, 32'd128);
    check("ready_init_busy", {31'b0, init_busy}, 32'h0);

    // Table-driven single-cycle accesses
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].w, vecs[i].clr, vecs[i].typ, vecs[i].addr, vecs[i].data);
      @(negedge clk);
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
      tick();
      check($sformatf("vec%0d_misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      check($sformatf("vec%0d_err_addr", i), err_addr, vecs[i].exp_err);
      check($sformatf("vec%0d_wr_count", i), {16'b0, wr_count}, {16'b0, vecs[i].exp_cnt});
    end
    idle();

    // wr_count saturates at all-ones (starts from 8 here)
    sat_n = 65535 - 8 - 1;
    for (int i = 0; i < sat_n; i++) begin
      drive(1'b1, 1'b0, T_W, 32'h60, i);
      tick();
    end
    check("sat_almost", {16'b0, wr_count}, 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, T_W, 32'h60, 32'hA5A5_0000 + i);
      tick();
    end
    idle();
    check("sat_hold", {16'b0, wr_count}, 32'h0000FFFF);
    drive(1'b0, 1'b0, T_W, 32'h60, 32'h0);
    #1;
    check("sat_last_store", dout, 32'hA5A5_0002);

    // Reset pulsed mid-sweep restarts the full clear
    reset = 1'b0;
    tick();
    reset = 1'b1;
    idle();
    repeat (60) tick();
    check("mid_init_busy", {31'b0, init_busy}, 32'h1);
    reset = 1'b0;
    tick();
    check("rerst_wr_count", {16'b0, wr_count}, 32'h0);
    reset = 1'b1;
    n = 0;
    while (init_busy && n < 300) begin
      drive(1'b1, 1'b0, T_W, (n < 10) ? 32'h11 : 32'h10, 32'h12345678);
      if (n == 20) check("rerst_init_dout", dout, 32'h0);
      tick();
      n++;
    end
    idle();
    check("rerst_init_cycles", n, 32'd128);
    check("rerst_store_ignored_cnt", {16'b0, wr_count}, 32'h0);
    check("rerst_no_misalign", {31'b0, misalign}, 32'h0);
    drive(1'b0, 1'b0, T_W, 32'h10, 32'h0);
    #1;
    check("rerst_word10_zero", dout, 32'h0);
    drive(1'b0, 1'b0, T_W, 32'h60, 32'h0);
    #1;
    check("rerst_word60_zero", dout, 32'h0);
    drive(1'b0, 1'b0, T_W, 32'h40, 32'h0);
    #1;
    check("rerst_word40_zero", dout, 32'h0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
